// File: rtl/way_select_mux_pipe.sv
`default_nettype none
//============================================================================
// Module      : way_select_mux_pipe
// Description : Pipelined N-way select for the set-associative cache read
//               path. Picks the hitting way's data word from all way read
//               data using a per-way hit vector, and forwards it with a hit
//               flag and encoded way index through a registered output stage
//               backed by a 2-entry skid buffer (valid/ready on both sides).
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
// Ports:
//   i_clk    in   1                 clock, rising edge
//   i_rst    in   1                 synchronous active-high reset
//   i_valid  in   1                 upstream request valid
//   o_ready  out  1                 request can be accepted this cycle
//   i_data   in   WAYS*DATA_WIDTH   way k at [k*DATA_WIDTH +: DATA_WIDTH]
//   i_sel    in   WAYS              per-way hit vector (one-hot or zero)
//   o_valid  out  1                 output beat valid
//   i_ready  in   1                 downstream accepts output beat
//   o_data   out  DATA_WIDTH        selected way data, zero on miss/error
//   o_hit    out  1                 exactly one select bit was set
//   o_way    out  WAY_BITS          index of lowest set select bit
//   o_err    out  1                 select vector was multi-hot
//
// Build option:
//   WAY_SEL_ONEHOT_CHECK_EN - when defined, multi-hot selects produce an
//   error beat (o_err=1, data/hit/way zeroed) and a saturating 8-bit error
//   beat counter r_err_cnt is kept. When undefined, o_err is tied low and
//   a multi-hot select ORs the selected ways together.
//============================================================================
module way_select_mux_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int WAYS       = 4,
    parameter int WAY_BITS   = $clog2(WAYS)
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [WAYS*DATA_WIDTH-1:0] i_data,
    input  logic [WAYS-1:0]            i_sel,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [DATA_WIDTH-1:0]      o_data,
    output logic                       o_hit,
    output logic [WAY_BITS-1:0]        o_way,
    output logic                       o_err
);

    localparam int c_CNT_W = $clog2(WAYS + 1);
    localparam int c_RES_W = DATA_WIDTH + WAY_BITS + 2;

    // Occupancy of the output register + skid buffer.
    localparam logic [1:0] c_ST_EMPTY = 2'd0;
    localparam logic [1:0] c_ST_ONE   = 2'd1;
    localparam logic [1:0] c_ST_TWO   = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic                  r_ready;
    logic [c_RES_W-1:0]    r_out;
    logic [c_RES_W-1:0]    r_skid;

    logic [DATA_WIDTH-1:0] w_or_data;
    logic [c_CNT_W-1:0]    w_pop;
    logic [WAY_BITS-1:0]   w_low_way;
    logic                  w_multi;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  w_hit;
    logic [WAY_BITS-1:0]   w_way;
    logic                  w_err;
    logic [c_RES_W-1:0]    w_res;

    logic                  w_accept;
    logic                  w_deliver;

    //------------------------------------------------------------------------
    // Select logic on the raw inputs
    //------------------------------------------------------------------------
    always_comb begin
        w_or_data = '0;
        w_pop     = '0;
        w_low_way = '0;
        for (int k = 0; k < WAYS; k++) begin
            w_or_data = w_or_data
                      | (i_data[k*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{i_sel[k]}});
            w_pop     = w_pop + c_CNT_W'(i_sel[k]);
        end
        // Walk from the top so the lowest set bit wins.
        for (int k = WAYS - 1; k >= 0; k--) begin
            if (i_sel[k]) begin
                w_low_way = WAY_BITS'(k);
            end
        end
    end

    assign w_multi = (w_pop > c_CNT_W'(1));
    assign w_hit   = (w_pop == c_CNT_W'(1));

`ifdef WAY_SEL_ONEHOT_CHECK_EN
    assign w_err  = w_multi;
    assign w_data = w_multi ? '0 : w_or_data;
    assign w_way  = w_multi ? '0 : w_low_way;
`else
    // Multi-hot is passed through unchecked: OR of selected ways.
    assign w_err  = 1'b0;
    assign w_data = w_or_data;
    assign w_way  = w_low_way;
`endif

    assign w_res = {w_err, w_hit, w_way, w_data};

    //------------------------------------------------------------------------
    // Handshake and occupancy state machine
    //------------------------------------------------------------------------
    assign w_accept  = i_valid && r_ready;
    assign w_deliver = (r_state != c_ST_EMPTY) && i_ready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_EMPTY: begin
                if (w_accept) w_state_nxt = c_ST_ONE;
            end
            c_ST_ONE: begin
                if (w_accept && !w_deliver)      w_state_nxt = c_ST_TWO;
                else if (!w_accept && w_deliver) w_state_nxt = c_ST_EMPTY;
            end
            c_ST_TWO: begin
                if (w_deliver) w_state_nxt = c_ST_ONE;
            end
            default: w_state_nxt = c_ST_EMPTY;
        endcase
    end

    // Ready is registered from the next state, so it never depends on
    // i_ready combinationally and stays low for the whole reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= c_ST_EMPTY;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt != c_ST_TWO);
        end
    end

    //------------------------------------------------------------------------
    // Output register and skid buffer
    //------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_out  <= '0;
            r_skid <= '0;
        end else begin
            case (r_state)
                c_ST_EMPTY: begin
                    if (w_accept) r_out <= w_res;
                end
                c_ST_ONE: begin
                    if (w_accept && w_deliver)  r_out  <= w_res;
                    else if (w_accept)          r_skid <= w_res;
                end
                c_ST_TWO: begin
                    if (w_deliver) r_out <= r_skid;
                end
                default: ;
            endcase
        end
    end

`ifdef WAY_SEL_ONEHOT_CHECK_EN
    // Sticky count of accepted error beats, saturating at 255.
    logic [7:0] r_err_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_err_cnt <= '0;
        end else if (w_accept && w_err && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end
`endif

    assign o_ready = r_ready;
    assign o_valid = (r_state != c_ST_EMPTY);
    assign {o_err, o_hit, o_way, o_data} = r_out;

endmodule
`default_nettype wire

// File: tb/tb_way_select_mux_pipe.sv
`default_nettype none
//============================================================================
// Module      : tb_way_select_mux_pipe
// Description : Self-checking bench for way_select_mux_pipe (WAYS=4,
//               DATA_WIDTH=32). Directed scenarios followed by random
//               traffic, checked against a queue-based reference model.
// Revision    : 1.0 - initial release
//============================================================================
module tb_way_select_mux_pipe;

    localparam int DW   = 32;
    localparam int WAYS = 4;
    localparam int WB   = 2;

    logic              clk;
    logic              i_rst;
    logic              i_valid;
    logic              o_ready;
    logic [WAYS*DW-1:0] i_data;
    logic [WAYS-1:0]   i_sel;
    logic              o_valid;
    logic              i_ready;
    logic [DW-1:0]     o_data;
    logic              o_hit;
    logic [WB-1:0]     o_way;
    logic              o_err;

    way_select_mux_pipe #(
        .DATA_WIDTH (DW),
        .WAYS       (WAYS)
    ) dut (
        .i_clk   (clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (i_data),
        .i_sel   (i_sel),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_hit   (o_hit),
        .o_way   (o_way),
        .o_err   (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          hit;
        logic [WB-1:0] way;
        logic          err;
    } beat_t;

    beat_t q[$];
    bit    in_rst;
    int    model_err_cnt;
    int    checks;
    int    errors;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected result from the select rules, using population count and
    // plain arithmetic on the way words.
    function automatic beat_t model(input logic [WAYS*DW-1:0] d, input logic [WAYS-1:0] s);
        beat_t b;
        int    n;
        int    low;
        n   = $countones(s);
        low = -1;
        b   = '0;
        for (int k = 0; k < WAYS; k++) begin
            if (s[k]) begin
                b.data = b.data | d[k*DW +: DW];
                if (low < 0) low = k;
            end
        end
        b.hit = (n == 1);
        b.way = (low < 0) ? 2'd0 : WB'(low);
`ifdef WAY_SEL_ONEHOT_CHECK_EN
        if (n >= 2) begin
            b.err  = 1'b1;
            b.data = '0;
            b.way  = '0;
        end
`endif
        return b;
    endfunction

    // One clock: compare outputs with the model, then advance the model
    // across the rising edge. Called at the falling edge with inputs set.
    task automatic tick();
        bit    exp_ready;
        bit    exp_valid;
        bit    acc;
        bit    del;
        beat_t nb;
        exp_ready = !in_rst && (q.size() < 2);
        exp_valid = (q.size() > 0);
        check("o_ready", 64'(o_ready), 64'(exp_ready));
        check("o_valid", 64'(o_valid), 64'(exp_valid));
        if (exp_valid) begin
            check("o_data", 64'(o_data), 64'(q[0].data));
            check("o_hit",  64'(o_hit),  64'(q[0].hit));
            check("o_way",  64'(o_way),  64'(q[0].way));
            check("o_err",  64'(o_err),  64'(q[0].err));
        end
        acc = !i_rst && i_valid && exp_ready;
        del = !i_rst && exp_valid && i_ready;
        nb  = model(i_data, i_sel);
        @(posedge clk);
        if (i_rst) begin
            q.delete();
            in_rst        = 1'b1;
            model_err_cnt = 0;
        end else begin
            in_rst = 1'b0;
            if (del) void'(q.pop_front());
            if (acc) begin
                q.push_back(nb);
                if (nb.err && model_err_cnt < 255) model_err_cnt++;
            end
        end
        @(negedge clk);
    endtask

    logic [WAYS*DW-1:0] dvec;
    logic [DW-1:0]      wa;
    logic [DW-1:0]      wb;

    initial begin
        checks        = 0;
        errors        = 0;
        in_rst        = 1'b1;
        model_err_cnt = 0;
        i_rst         = 1'b1;
        i_valid       = 1'b0;
        i_ready       = 1'b0;
        i_data        = '0;
        i_sel         = '0;
        @(posedge clk);
        @(negedge clk);

        // Reset held for three cycles: everything low.
        for (int i = 0; i < 3; i++) begin
            check("rst_data",  64'(o_data),  64'd0);
            check("rst_hit",   64'(o_hit),   64'd0);
            check("rst_way",   64'(o_way),   64'd0);
            check("rst_err",   64'(o_err),   64'd0);
            tick();
        end
        i_rst = 1'b0;
        tick();
        check("post_rst_ready", 64'(o_ready), 64'd1);
        check("post_rst_valid", 64'(o_valid), 64'd0);

        // Single hit on way 2.
        dvec    = {32'h11111111, 32'hDEADBEEF, 32'h11111111, 32'h11111111};
        i_data  = dvec;
        i_sel   = 4'b0100;
        i_valid = 1'b1;
        i_ready = 1'b1;
        tick();
        i_valid = 1'b0;
        i_sel   = 4'b1111;
        check("hit_valid", 64'(o_valid), 64'd1);
        check("hit_data",  64'(o_data),  64'hDEADBEEF);
        check("hit_hit",   64'(o_hit),   64'd1);
        check("hit_way",   64'(o_way),   64'd2);
        tick();

        // Miss.
        i_sel   = 4'b0000;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        check("miss_valid", 64'(o_valid), 64'd1);
        check("miss_data",  64'(o_data),  64'd0);
        check("miss_hit",   64'(o_hit),   64'd0);
        check("miss_err",   64'(o_err),   64'd0);
        tick();

        // Backpressure: A (way0) and B (way3) back-to-back, sink stalled.
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_data  = {32'hBBBB0003, 32'h22222222, 32'h33333333, 32'hAAAA0000};
        i_sel   = 4'b0001;
        tick();
        i_sel   = 4'b1000;
        tick();
        i_valid = 1'b0;
        i_data  = '0;
        for (int i = 0; i < 3; i++) begin
            check("bp_ready_low", 64'(o_ready), 64'd0);
            check("bp_hold_a",    64'(o_data),  64'hAAAA0000);
            tick();
        end
        i_ready = 1'b1;
        tick();
        check("bp_b_data",  64'(o_data),  64'hBBBB0003);
        check("bp_b_way",   64'(o_way),   64'd3);
        check("bp_ready_up", 64'(o_ready), 64'd1);
        tick();
        tick();

        // Multi-hot select.
        wa      = 32'h0F0F0000;
        wb      = 32'h00F000F0;
        i_data  = {32'h12345678, wb, wa, 32'h87654321};
        i_sel   = 4'b0110;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
`ifdef WAY_SEL_ONEHOT_CHECK_EN
        check("mh_err",  64'(o_err),  64'd1);
        check("mh_hit",  64'(o_hit),  64'd0);
        check("mh_data", 64'(o_data), 64'd0);
        check("mh_cnt",  64'(dut.r_err_cnt), 64'd1);
`else
        check("mh_err",  64'(o_err),  64'd0);
        check("mh_data", 64'(o_data), 64'(wa | wb));
        check("mh_way",  64'(o_way),  64'd1);
`endif
        tick();

        // Reset while both stages are full.
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_sel   = 4'b0010;
        tick();
        tick();
        i_valid = 1'b0;
        check("two_ready", 64'(o_ready), 64'd0);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        check("midrst_valid", 64'(o_valid), 64'd0);
        i_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check("midrst_no_stale", 64'(o_valid), 64'd0);
            tick();
        end

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            i_rst   = ($urandom_range(0, 99) == 0);
            i_valid = $urandom_range(0, 3) != 0;
            i_ready = $urandom_range(0, 2) != 0;
            i_data  = {$urandom, $urandom, $urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       i_sel = 4'b0000;
                1, 2:    i_sel = 4'b0001 << $urandom_range(0, 3);
                default: i_sel = 4'($urandom_range(0, 15));
            endcase
            tick();
        end
        i_rst   = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
`ifdef WAY_SEL_ONEHOT_CHECK_EN
        check("err_cnt_final", 64'(dut.r_err_cnt), 64'(model_err_cnt));
`endif
        check("drained", 64'(o_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
